// File: rtl/rng_pkg.sv
// Shared constants and types for the MT19937 random-number stream.
//   N, M            : state array length and twist offset
//   F               : seeding multiplier
//   MATRIX_A        : twist matrix constant
//   UPPER/LOWER_MASK: word split used by the twist
//   TEMPER_*        : tempering shifts and masks
//   state_t         : top-level sequencer states
package rng_pkg;

  localparam int N     = 624;
  localparam int M     = 397;
  localparam int IDX_W = 10;

  localparam logic [31:0] F          = 32'd1812433253;
  localparam logic [31:0] MATRIX_A   = 32'h9908B0DF;
  localparam logic [31:0] UPPER_MASK = 32'h80000000;
  localparam logic [31:0] LOWER_MASK = 32'h7FFFFFFF;

  localparam int          TEMPER_U = 11;
  localparam int          TEMPER_S = 7;
  localparam int          TEMPER_T = 15;
  localparam int          TEMPER_L = 18;
  localparam logic [31:0] TEMPER_B = 32'h9D2C5680;
  localparam logic [31:0] TEMPER_C = 32'hEFC60000;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t IDX_N    = idx_t'(N);
  localparam idx_t IDX_LAST = idx_t'(N - 1);
  localparam idx_t IDX_M    = idx_t'(M);
  localparam idx_t IDX_N_M  = idx_t'(N - M);

  typedef enum logic [1:0] {
    ST_SEED,
    ST_TWIST,
    ST_LOAD,
    ST_SERVE
  } state_t;

endpackage

// File: rtl/mt_temper.sv
// MT19937 tempering: a purely combinational 32-bit to 32-bit bijection.
//   y_in  : raw state word
//   y_out : tempered output word
module mt_temper
  import rng_pkg::*;
(
  input  logic [31:0] y_in,
  output logic [31:0] y_out
);

  logic [31:0] y1, y2, y3;

  always_comb begin
    y1    = y_in ^ (y_in >> TEMPER_U);
    y2    = y1 ^ ((y1 << TEMPER_S) & TEMPER_B);
    y3    = y2 ^ ((y2 << TEMPER_T) & TEMPER_C);
    y_out = y3 ^ (y3 >> TEMPER_L);
  end

endmodule

// File: rtl/mt_rng_stream.sv
// MT19937 random-number source with a valid/ready output stream.
// Seeds the 624-word state one word per cycle, twists it in place one word
// per cycle, then serves tempered words at one per cycle, prefetching the
// next word on every handshake. Output is either the top OUT_W bits of the
// word (range == 0) or the word scaled onto [0, range).
//   clk, rst_n : clock, synchronous active-low reset
//   seed       : seed value, captured on reseed
//   reseed     : one-cycle pulse restarting seeding from seed
//   range      : 0 = raw mode, otherwise bounded-range mode
//   rnd_ready  : consumer accepts rnd_data
//   rnd_valid  : rnd_data holds an unconsumed word
//   rnd_data   : random output
//   busy       : high while seeding or twisting
module mt_rng_stream
  import rng_pkg::*;
#(
  parameter logic [31:0] DEFAULT_SEED = 32'd5489,
  parameter int          OUT_W        = 32,
  parameter int          RANGE_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        seed,
  input  logic               reseed,
  input  logic [RANGE_W-1:0] range,
  input  logic               rnd_ready,
  output logic               rnd_valid,
  output logic [OUT_W-1:0]   rnd_data,
  output logic               busy
);

  state_t      state, state_nxt;
  idx_t        i_q;        // seed/twist write index
  idx_t        idx_q;      // next word to serve
  logic [31:0] seed_q;
  logic [31:0] prev_q;     // previous word written while seeding
  logic [31:0] word_q;     // currently presented raw word
  logic        valid_q;

  logic [31:0] mt [0:N-1];

  idx_t        i_next, i_plus_m, rd_addr;
  logic [31:0] y_twist, twist_word, seed_word;
  logic [31:0] tempered;
  logic [63:0] product;
  logic [31:0] scaled;
  logic        handshake;

  assign handshake = valid_q && rnd_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_SEED;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_nxt = state;
    if (reseed) begin
      state_nxt = ST_SEED;
    end else begin
      case (state)
        ST_SEED:  if (i_q == IDX_LAST) state_nxt = ST_TWIST;
        ST_TWIST: if (i_q == IDX_LAST) state_nxt = ST_LOAD;
        ST_LOAD:  state_nxt = ST_SERVE;
        ST_SERVE: if (handshake && idx_q == IDX_N) state_nxt = ST_TWIST;
        default:  state_nxt = ST_SEED;
      endcase
    end
  end

  always_comb begin
    busy = (state == ST_SEED) || (state == ST_TWIST);
  end

  // ------------------------------------------------------- word datapath
  always_comb begin
    i_next   = (i_q == IDX_LAST) ? '0 : i_q + idx_t'(1);
    // (i + M) mod N without a divider; i never exceeds N-1 here.
    i_plus_m = (i_q >= IDX_N_M) ? i_q - IDX_N_M : i_q + IDX_M;
    // In-place update: for i >= N-M, mt[i_plus_m] is already the new word.
    y_twist    = (mt[i_q] & UPPER_MASK) | (mt[i_next] & LOWER_MASK);
    twist_word = mt[i_plus_m] ^ (y_twist >> 1) ^ (y_twist[0] ? MATRIX_A : 32'h0);
    seed_word  = (i_q == '0) ? seed_q
                             : F * (prev_q ^ (prev_q >> 30)) + 32'(i_q);
    // LOAD reads word 0; SERVE prefetches idx. idx == N is never consumed.
    rd_addr    = (state == ST_SERVE && idx_q < IDX_N) ? idx_q : '0;
  end

  mt_temper u_temper (
    .y_in  (mt[rd_addr]),
    .y_out (tempered)
  );

  // NOTE: the state array is deliberately not reset; seeding overwrites
  // every word before any of it is read, and a reset here would turn the
  // array into 20k flops with reset muxes.
  always_ff @(posedge clk) begin
    if (rst_n && !reseed) begin
      case (state)
        ST_SEED:  mt[i_q] <= seed_word;
        ST_TWIST: mt[i_q] <= twist_word;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_q  <= DEFAULT_SEED;
      prev_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      i_q     <= '0;
      idx_q   <= '0;
    end else if (reseed) begin
      seed_q  <= seed;
      valid_q <= 1'b0;
      i_q     <= '0;
      idx_q   <= '0;
    end else begin
      case (state)
        ST_SEED: begin
          prev_q <= seed_word;
          i_q    <= i_next;
        end
        ST_TWIST: begin
          i_q <= i_next;
        end
        ST_LOAD: begin
          word_q  <= tempered;
          idx_q   <= idx_t'(1);
          valid_q <= 1'b1;
        end
        ST_SERVE: begin
          if (handshake) begin
            if (idx_q == IDX_N) begin
              valid_q <= 1'b0;
              i_q     <= '0;
            end else begin
              word_q <= tempered;
              idx_q  <= idx_q + idx_t'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------- output
  // Bounded mode keeps the high half of word*range, mapping the full 32-bit
  // word space uniformly onto [0, range).
  always_comb begin
    product = 64'(word_q) * 64'(range);
    scaled  = 32'(product >> 32);
    if (range == '0) rnd_data = word_q[31 -: OUT_W];
    else             rnd_data = scaled[OUT_W-1:0];
  end

  assign rnd_valid = valid_q;

endmodule
